divide_prog_n: RTL and testbench
================================

// Module: divide_prog_n
// PURPOSE
//  Runtime-programmable divide-by-N counter. It is the parametrised successor
//  to the fixed divide-by-N stage. Adds a loadable divisor, count enable,
//  pulse or ~50% square output mode, glitch-free divisor change at wrap, and
//  an error flag. Feeds slow-tick and clock-enable chains, e.g. 1 Hz from a
//  board clock, by cascading stages through TICK -> ENABLE.
// PARAMETERS
//  W            10    counter/divisor width in bits; legal divisors 2..2^W-1
//  DEFAULT_DIV  1000  divisor after reset; must be 2..2^W-1
// PORTS
//  CLOCK    in   1  clock; all state updates on the falling edge
//  CLEAR    in   1  asynchronous active-low reset
//  ENABLE   in   1  count enable; 1 = advance on this edge
//  MODE     in   1  0 = OUT is the TICK pulse; 1 = OUT is the square wave
//  LOAD     in   1  1 on an edge = capture DIV_IN as the pending divisor
//  DIV_IN   in   W  new divisor value
//  COUNT    out  W  current count, 0..DIV-1
//  TICK     out  1  high while COUNT==DIV-1 and the last edge was enabled
//  OUT      out  1  mode-selected output, registered
//  PENDING  out  1  a loaded divisor is waiting for the next wrap
//  DIV_ERR  out  1  sticky: the last LOAD was rejected (DIV_IN < 2)
//  DIV      out  W  active divisor
// BEHAVIOUR
//  Reset (CLEAR=0, any time, asynchronous):
//  - COUNT=0, TICK=0, OUT=0, PENDING=0, DIV_ERR=0, DIV=DEFAULT_DIV.
//  - The pending register is loaded with DEFAULT_DIV.
//  - A reset mid-period abandons both the period and any pending load.
//  Counting, on each falling edge with ENABLE=1:
//  - COUNT <= (COUNT==DIV-1) ? 0 : COUNT+1. The edge that takes COUNT back to 0 is the "wrap".
//  - TICK <= (next COUNT == next DIV-1). The result is one TICK-high cycle per DIV enabled edges.
//  Square output (MODE=1):
//  - OUT <= (next COUNT < next DIV - next DIV/2), using integer divide.
//  - High for ceil(DIV/2) counts and low for floor(DIV/2) counts; DIV=5 gives 3 high, 2 low.
//  - MODE=0: OUT <= the next value of TICK.
//  - A MODE change takes effect on the next edge; it never touches COUNT.
//  ENABLE=0:
//  - COUNT, DIV and the pending register hold.
//  - TICK <= 0 on that edge. OUT <= 0 in MODE 0; OUT holds in MODE 1.
//  Divisor load, on an edge with LOAD=1:
//  - DIV_IN >= 2: the pending register <= DIV_IN, PENDING <= 1, DIV_ERR <= 0.
//  - DIV_IN < 2: the load is ignored; DIV_ERR <= 1. The pending register and PENDING are unchanged.
//  - A second LOAD before the wrap overwrites the pending value (last wins).
//  Divisor apply:
//  - On a wrap edge with PENDING=1, DIV <= the pending value and PENDING <= 0.
//  - TICK and OUT on that edge use the new DIV.
//  - LOAD on the wrap edge itself: DIV_IN is applied directly on that edge and PENDING stays 0.
//  - ENABLE=0 with PENDING=1: applied on the next disabled edge; COUNT <= 0.
//  - COUNT can never reach or exceed the active DIV; no truncation occurs.
//  Widths: all compares are W bits wide. DIV-1 and DIV/2 are computed in W bits.
//  DIV >= 2 is guaranteed, so no underflow occurs.
// TESTING
//  1. Reset with W=4, DEFAULT_DIV=5, ENABLE=1, MODE=0 -> COUNT 0,1,2,3,4,0...;
//     TICK/OUT high only while COUNT=4, once every 5 edges.
//  2. MODE=1, DIV=5 -> OUT pattern 1,1,1,0,0 repeating. DIV=4 -> 1,1,0,0.
//  3. LOAD DIV_IN=3 at COUNT=1 -> PENDING=1. COUNT reaches 4 and wraps.
//     Then DIV=3, PENDING=0, TICK every 3 edges.
//  4. LOAD DIV_IN=1 -> DIV_ERR=1 with DIV and PENDING unchanged.
//     A later LOAD DIV_IN=6 -> DIV_ERR=0.
//  5. ENABLE=0 for 7 edges at COUNT=2 -> COUNT stays 2 and TICK=0.
//     Re-enable -> TICK appears 2 edges later. Then drive ENABLE=TICK of a
//     second stage (DIV=5) -> that stage ticks once per 25 edges.
//  6. Pull CLEAR low mid-period with PENDING=1 -> all outputs reset at once,
//     with no clock edge needed. DIV=DEFAULT_DIV and PENDING=0.

Source files
------------

// File: rtl/divide_prog_n.sv
// divide_prog_n: runtime-programmable divide-by-N counter
// falling-edge state, pulse or square output, safe divisor swap at wrap
module divide_prog_n #(
  parameter int W           = 10,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic         CLOCK,
  input  logic         CLEAR,
  input  logic         ENABLE,
  input  logic         MODE,
  input  logic         LOAD,
  input  logic [W-1:0] DIV_IN,
  output logic [W-1:0] COUNT,
  output logic         TICK,
  output logic         OUT,
  output logic         PENDING,
  output logic         DIV_ERR,
  output logic [W-1:0] DIV
);

  localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);

  logic [W-1:0] pend_q;
  logic [W-1:0] div_m1;
  logic [W-1:0] cnt_n;
  logic [W-1:0] div_n;
  logic [W-1:0] pend_n;
  logic [W-1:0] half_n;
  logic         wrap;
  logic         apply;
  logic         ld_ok;
  logic         ld_bad;
  logic         pending_n;
  logic         tick_n;
  logic         sq_n;

  // next-state: count advance, divisor swap at wrap, pending capture
  always_comb begin
    div_m1    = DIV - W'(1);
    wrap      = ENABLE && (COUNT == div_m1);
    apply     = wrap || (!ENABLE && PENDING);
    ld_ok     = LOAD && (DIV_IN >= W'(2));
    ld_bad    = LOAD && !ld_ok;
    cnt_n     = COUNT;
    div_n     = DIV;
    pend_n    = pend_q;
    pending_n = PENDING;
    if (ENABLE) begin
      cnt_n = wrap ? '0 : COUNT + W'(1);
    end
    if (apply) begin
      if (!ENABLE) begin
        cnt_n = '0;
      end
      pending_n = 1'b0;
      if (ld_ok) begin
        div_n = DIV_IN;
      end else if (PENDING) begin
        div_n = pend_q;
      end
    end else if (ld_ok) begin
      pend_n    = DIV_IN;
      pending_n = 1'b1;
    end
    half_n = div_n >> 1;
    tick_n = ENABLE && (cnt_n == div_n - W'(1));
    sq_n   = cnt_n < (div_n - half_n);
  end

  // state and registered outputs, falling edge, async clear
  always_ff @(negedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      COUNT   <= '0;
      TICK    <= 1'b0;
      OUT     <= 1'b0;
      PENDING <= 1'b0;
      DIV_ERR <= 1'b0;
      DIV     <= DEF;
      pend_q  <= DEF;
    end else begin
      COUNT   <= cnt_n;
      DIV     <= div_n;
      pend_q  <= pend_n;
      PENDING <= pending_n;
      TICK    <= tick_n;
      if (ld_ok) begin
        DIV_ERR <= 1'b0;
      end else if (ld_bad) begin
        DIV_ERR <= 1'b1;
      end
      if (MODE) begin
        OUT <= ENABLE ? sq_n : OUT;
      end else begin
        OUT <= tick_n;
      end
    end
  end

endmodule

// File: tb/tb_divide_prog_n.sv
// tb_divide_prog_n: vector table, random vs model, cascade, async clear
// W=4, DEFAULT_DIV=5
module tb_divide_prog_n;
  localparam int W  = 4;
  localparam int DD = 5;

  logic         clk = 1'b0;
  logic         clr;
  logic         en, mode, load;
  logic [W-1:0] divin;
  logic [W-1:0] cnt, div;
  logic         tick, out, pend, err;
  logic [W-1:0] c2, d2;
  logic         t2, o2, p2, e2;

  divide_prog_n #(.W(W), .DEFAULT_DIV(DD)) u1 (
    .CLOCK(clk), .CLEAR(clr), .ENABLE(en), .MODE(mode),
    .LOAD(load), .DIV_IN(divin), .COUNT(cnt), .TICK(tick),
    .OUT(out), .PENDING(pend), .DIV_ERR(err), .DIV(div)
  );

  divide_prog_n #(.W(W), .DEFAULT_DIV(DD)) u2 (
    .CLOCK(clk), .CLEAR(clr), .ENABLE(tick), .MODE(1'b0),
    .LOAD(1'b0), .DIV_IN('0), .COUNT(c2), .TICK(t2),
    .OUT(o2), .PENDING(p2), .DIV_ERR(e2), .DIV(d2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int m_cnt, m_div, m_pnd_v, m_pnd, m_tick, m_out, m_err;

  typedef struct {
    bit e; bit m; bit l; int dv;
    int c; bit t; bit o; bit p; bit er; int d;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit e, bit m, bit l, int dv,
                              int c, bit t, bit o, bit p,
                              bit er, int d);
    vec_t v;
    v = '{e, m, l, dv, c, t, o, p, er, d};
    tbl.push_back(v);
  endfunction

  function automatic void m_reset();
    m_cnt = 0; m_div = DD; m_pnd_v = DD; m_pnd = 0;
    m_tick = 0; m_out = 0; m_err = 0;
  endfunction

  // reference: spec rules in plain integer arithmetic
  function automatic void m_step(bit e, bit m, bit l, int dv);
    bit at_end, swap, good;
    at_end = e && (m_cnt == m_div - 1);
    swap   = at_end || (!e && m_pnd != 0);
    good   = l && (dv >= 2);
    if (l) m_err = good ? 0 : 1;
    if (e) m_cnt = at_end ? 0 : m_cnt + 1;
    if (swap) begin
      if (!e) m_cnt = 0;
      if (good) m_div = dv;
      else if (m_pnd != 0) m_div = m_pnd_v;
      m_pnd = 0;
    end else if (good) begin
      m_pnd_v = dv;
      m_pnd = 1;
    end
    m_tick = (e && m_cnt == m_div - 1) ? 1 : 0;
    if (!m) m_out = m_tick;
    else if (e) m_out = (m_cnt < (m_div + 1) / 2) ? 1 : 0;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tg, int c, int t, int o,
                         int p, int er, int d);
    chk({tg, ".cnt"}, 16'(cnt), 16'(c));
    chk({tg, ".tick"}, 16'(tick), 16'(t));
    chk({tg, ".out"}, 16'(out), 16'(o));
    chk({tg, ".pend"}, 16'(pend), 16'(p));
    chk({tg, ".err"}, 16'(err), 16'(er));
    chk({tg, ".div"}, 16'(div), 16'(d));
  endtask

  task automatic step(bit e, bit m, bit l, int dv);
    en = e; mode = m; load = l; divin = W'(dv);
    @(negedge clk);
    m_step(e, m, l, dv);
    @(posedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #2;
    @(posedge clk);
    clr = 1'b1;
    m_reset();
  endtask

  initial begin
    int first, second;
    clr = 1'b0; en = 0; mode = 0; load = 0; divin = '0;
    m_reset();
    #12;
    chk_all("rst", 0, 0, 0, 0, 0, DD);
    @(posedge clk);
    clr = 1'b1;

    add(1,0,0,0, 1,0,0,0,0,5);
    add(1,0,0,0, 2,0,0,0,0,5);
    add(1,0,0,0, 3,0,0,0,0,5);
    add(1,0,0,0, 4,1,1,0,0,5);
    add(1,0,0,0, 0,0,0,0,0,5);
    add(1,1,0,0, 1,0,1,0,0,5);
    add(1,1,0,0, 2,0,1,0,0,5);
    add(1,1,0,0, 3,0,0,0,0,5);
    add(1,1,0,0, 4,1,0,0,0,5);
    add(1,1,0,0, 0,0,1,0,0,5);
    add(1,0,1,3, 1,0,0,1,0,5);
    add(1,0,0,0, 2,0,0,1,0,5);
    add(1,0,0,0, 3,0,0,1,0,5);
    add(1,0,0,0, 4,1,1,1,0,5);
    add(1,0,0,0, 0,0,0,0,0,3);
    add(1,0,0,0, 1,0,0,0,0,3);
    add(1,0,0,0, 2,1,1,0,0,3);
    add(1,0,0,0, 0,0,0,0,0,3);
    add(1,0,1,1, 1,0,0,0,1,3);
    add(1,0,0,0, 2,1,1,0,1,3);
    add(1,0,1,6, 0,0,0,0,0,6);
    add(1,0,1,7, 1,0,0,1,0,6);
    add(1,0,1,0, 2,0,0,1,1,6);
    add(1,0,0,0, 3,0,0,1,1,6);
    add(1,0,0,0, 4,0,0,1,1,6);
    add(1,0,0,0, 5,1,1,1,1,6);
    add(1,0,0,0, 0,0,0,0,1,7);
    add(1,0,1,5, 1,0,0,1,0,7);
    add(0,0,0,0, 0,0,0,0,0,5);
    add(1,0,0,0, 1,0,0,0,0,5);
    add(1,0,0,0, 2,0,0,0,0,5);
    for (int i = 0; i < 7; i++)
      add(0,0,0,0, 2,0,0,0,0,5);
    add(1,0,0,0, 3,0,0,0,0,5);
    add(1,0,0,0, 4,1,1,0,0,5);
    add(0,1,0,0, 4,0,1,0,0,5);
    add(1,1,0,0, 0,0,1,0,0,5);
    add(0,0,0,0, 0,0,0,0,0,5);
    add(1,1,1,4, 1,0,1,1,0,5);
    add(1,1,0,0, 2,0,1,1,0,5);
    add(1,1,0,0, 3,0,0,1,0,5);
    add(1,1,0,0, 4,1,0,1,0,5);
    add(1,1,0,0, 0,0,1,0,0,4);
    add(1,1,0,0, 1,0,1,0,0,4);
    add(1,1,0,0, 2,0,0,0,0,4);
    add(1,1,0,0, 3,1,0,0,0,4);
    add(1,1,0,0, 0,0,1,0,0,4);

    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].m, tbl[i].l, tbl[i].dv);
      chk_all($sformatf("v%0d", i), tbl[i].c, tbl[i].t,
              tbl[i].o, tbl[i].p, tbl[i].er, tbl[i].d);
    end

    // async clear mid-period with a load pending
    step(1, 0, 1, 3);
    step(1, 0, 0, 0);
    chk("pre_clr.pend", 16'(pend), 16'd1);
    #2;
    clr = 1'b0;
    #1;
    chk_all("aclr", 0, 0, 0, 0, 0, DD);
    clr = 1'b1;
    m_reset();

    // random traffic against the model
    mode = 0;
    for (int k = 0; k < 400; k++) begin
      bit e, m, l;
      int dv;
      e  = ($urandom_range(0, 3) != 0);
      m  = ($urandom_range(0, 15) == 0) ? !mode : mode;
      l  = ($urandom_range(0, 7) == 0);
      dv = $urandom_range(0, 15);
      step(e, m, l, dv);
      chk_all($sformatf("r%0d", k), m_cnt, m_tick,
              m_out, m_pnd, m_err, m_div);
    end

    // cascade: stage 2 enabled by stage 1 tick
    do_reset();
    first = -1;
    second = -1;
    for (int k = 1; k <= 80; k++) begin
      step(1, 0, 0, 0);
      if (t2 === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk("casc.first", 16'(first), 16'd20);
    chk("casc.period", 16'(second - first), 16'd25);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
